// File: rtl/vga_rect_pkg.sv
// vga_rect_pkg: shared states, register map, field positions and pixel-word packing for the rectangle filler
package vga_rect_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_e;
  localparam logic [2:0] REG_ORIGIN = 3'd0;
  localparam logic [2:0] REG_SIZE = 3'd1;
  localparam logic [2:0] REG_COLOUR = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam int X_LSB = 16;
  localparam int Y_LSB = 24;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_IRQ = 2;
  function automatic logic [31:0] pack_pixel(input logic [7:0] x, input logic [6:0] y, input logic [7:0] brightness);
    return {1'b0, y, x, 8'h00, brightness};
  endfunction
endpackage

// File: rtl/vga_rect_scanner.sv
// vga_rect_scanner: row-major x/y raster counter over [x0,x_end) x [y0,y_end)
// Ports: clk, reset_n (async active-low); load_i latches x0_i/y0_i/x_end_i/y_end_i;
// advance_i steps one pixel; x_o/y_o current pixel; last_o high on the final pixel.
module vga_rect_scanner (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] x0_i,
  input  logic [6:0] y0_i,
  input  logic [8:0] x_end_i,
  input  logic [7:0] y_end_i,
  input  logic       advance_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       last_o
);
  logic [7:0] x_q, x_d, x0_q, x0_d;
  logic [6:0] y_q, y_d;
  logic [8:0] x_end_q, x_end_d;
  logic [7:0] y_end_q, y_end_d;
  logic       x_wrap;
  assign x_wrap = ({1'b0, x_q} + 9'd1) == x_end_q;
  assign last_o = x_wrap && (({1'b0, y_q} + 8'd1) == y_end_q);
  assign x_o = x_q;
  assign y_o = y_q;
  always_comb begin
    x0_d = load_i ? x0_i : x0_q;
    x_end_d = load_i ? x_end_i : x_end_q;
    y_end_d = load_i ? y_end_i : y_end_q;
    x_d = load_i ? x0_i : advance_i ? (x_wrap ? x0_q : x_q + 8'd1) : x_q;
    y_d = load_i ? y0_i : (advance_i && x_wrap) ? y_q + 7'd1 : y_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      x0_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      x0_q <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
    end
  end
endmodule

// File: rtl/vga_rect_filler.sv
// vga_rect_filler: Avalon-MM programmed rectangle fill engine issuing clipped pixel-plot writes
// Slave: address/read/readdata (zero latency)/write/writedata. Master: m_address (0),
// m_write, m_writedata, m_waitrequest. Optional irq output when VGA_RECT_FILLER_IRQ_EN is defined.
module vga_rect_filler
  import vga_rect_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef VGA_RECT_FILLER_IRQ_EN
  ,
  output logic        irq
`endif
);
  state_e     state_q, state_d;
  logic [7:0] x0_q, x0_d, w_q, w_d, bright_q, bright_d;
  logic [6:0] y0_q, y0_d, h_q, h_d;
  logic [7:0] sx0_q, sx0_d, sw_q, sw_d, sb_q, sb_d;
  logic [6:0] sy0_q, sy0_d, sh_q, sh_d;
  logic       done_q, done_d;
  logic       wr_ctrl, start, clr, busy, empty, load, adv, last, irq_en;
  logic [8:0] x_sum, x_end;
  logic [7:0] y_sum, y_end;
  logic [7:0] x;
  logic [6:0] y;
  logic       unused;
  assign wr_ctrl = write && address == REG_CTRL;
  assign start = wr_ctrl && writedata[CTRL_START] && state_q == IDLE;
  assign clr = wr_ctrl && writedata[CTRL_CLR];
  assign busy = state_q != IDLE;
  // Clip bounds come from the snapshot, so they stay valid through SETUP regardless of CPU writes.
  assign x_sum = {1'b0, sx0_q} + {1'b0, sw_q};
  assign y_sum = {1'b0, sy0_q} + {1'b0, sh_q};
  assign x_end = x_sum > 9'(SCREEN_W) ? 9'(SCREEN_W) : x_sum;
  assign y_end = y_sum > 8'(SCREEN_H) ? 8'(SCREEN_H) : y_sum;
  assign empty = sw_q == '0 || sh_q == '0 || {1'b0, sx0_q} >= 9'(SCREEN_W) || {1'b0, sy0_q} >= 8'(SCREEN_H);
  assign load = state_q == SETUP && !empty;
  assign adv = state_q == DRAW && !m_waitrequest;
  assign m_address = 4'd0;
  assign m_write = state_q == DRAW;
  assign m_writedata = m_write ? pack_pixel(x, y, sb_q) : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? SETUP : IDLE;
      SETUP: state_d = empty ? DONE : DRAW;
      DRAW: state_d = (adv && last) ? DONE : DRAW;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    {y0_d, x0_d} = (write && address == REG_ORIGIN) ? {writedata[Y_LSB +: 7], writedata[X_LSB +: 8]} : {y0_q, x0_q};
    {h_d, w_d} = (write && address == REG_SIZE) ? {writedata[Y_LSB +: 7], writedata[X_LSB +: 8]} : {h_q, w_q};
    bright_d = (write && address == REG_COLOUR) ? writedata[7:0] : bright_q;
    {sy0_d, sx0_d, sh_d, sw_d, sb_d} = start ? {y0_q, x0_q, h_q, w_q, bright_q} : {sy0_q, sx0_q, sh_q, sw_q, sb_q};
    done_d = state_q == DONE || (done_q && !clr);
  end
  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        REG_ORIGIN: readdata = {1'b0, y0_q, x0_q, 16'h0000};
        REG_SIZE: readdata = {1'b0, h_q, w_q, 16'h0000};
        REG_COLOUR: readdata = {24'h0, bright_q};
        REG_CTRL: readdata = {29'h0, irq_en, done_q, busy};
        default: readdata = '0;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      {x0_q, y0_q, w_q, h_q, bright_q} <= '0;
      {sx0_q, sy0_q, sw_q, sh_q, sb_q} <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {x0_q, y0_q, w_q, h_q, bright_q} <= {x0_d, y0_d, w_d, h_d, bright_d};
      {sx0_q, sy0_q, sw_q, sh_q, sb_q} <= {sx0_d, sy0_d, sw_d, sh_d, sb_d};
      done_q <= done_d;
    end
  end
`ifdef VGA_RECT_FILLER_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = wr_ctrl ? writedata[CTRL_IRQ] : irq_en_q;
  assign irq_en = irq_en_q;
  assign irq = irq_q;
  // Built from next-state values so irq falls together with done after a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q <= done_d && irq_en_d;
    end
  end
  assign unused = ^{writedata[31], writedata[15:8]};
`else
  assign irq_en = 1'b0;
  assign unused = ^{writedata[31], writedata[15:8], writedata[CTRL_IRQ]};
`endif
  vga_rect_scanner u_scan (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (load),
    .x0_i     (sx0_q),
    .y0_i     (sy0_q),
    .x_end_i  (x_end),
    .y_end_i  (y_end),
    .advance_i(adv),
    .x_o      (x),
    .y_o      (y),
    .last_o   (last)
  );
endmodule
